s2p_frame_rx: RTL

Frame-level receive controller for the serial-to-parallel path. It samples a qualified serial bit stream inside a `frame` window and groups the bits MSB-first into bytes. Completed bytes are tagged with an end-of-frame marker and buffered in a small FIFO. The FIFO drains through a valid/ready byte interface to the downstream consumer, and the block pulses error flags on malformed frames.

---
 rtl/s2p_frame_rx_pkg.sv | 17 +
 rtl/s2p_byte_fifo.sv | 59 +++++
 rtl/s2p_frame_rx.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/s2p_frame_rx_pkg.sv
// Shared types and constants for the serial-to-parallel frame receiver.
package s2p_frame_rx_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHIFT   = 2'd1,
      DISCARD = 2'd2
   } state_e;

   typedef struct packed {
      logic              last;
      logic [BYTE_W-1:0] data;
   } fifo_entry_t;

endpackage

// File: rtl/s2p_byte_fifo.sv
// Synchronous byte FIFO; a push while full succeeds only if a pop happens in the same cycle.
module s2p_byte_fifo
   import s2p_frame_rx_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        push,
   input  fifo_entry_t push_entry,
   input  logic        pop,
   output fifo_entry_t head,
   output logic        full,
   output logic        empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH) + 1;

   fifo_entry_t      mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic             wr_en;
   logic             rd_en;

   // Status flags from the extra pointer wrap bit.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                  (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);

   // Head is forced to zero while empty so outputs read 0 after reset.
   assign head = empty ? '0 : mem_q[rd_ptr_q[PTR_W-2:0]];

   // Write/read enables and pointer next state.
   always_comb begin
      wr_en    = push && (!full || pop);
      rd_en    = pop && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
   end

   // Pointer registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q[PTR_W-2:0]] <= push_entry;
   end

endmodule

// File: rtl/s2p_frame_rx.sv
// Frame receive controller: assembles MSB-first bytes inside a frame window and queues them.
module s2p_frame_rx
   import s2p_frame_rx_pkg::*;
#(
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned MAX_BYTES = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              frame,
   input  logic              bit_valid,
   input  logic              bit_data,
   output logic [BYTE_W-1:0] m_data,
   output logic              m_last,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              err_partial,
   output logic              err_overflow,
   output logic              err_long,
   output logic              busy
);

   localparam int unsigned CNT_W = $clog2(MAX_BYTES + 1);

   // The shift register keeps the first seven bits; the eighth goes straight to pending.
   state_e              state_q, state_d;
   logic [BYTE_W-2:0]   shift_q, shift_d;
   logic [2:0]          bitcnt_q, bitcnt_d;
   logic [CNT_W-1:0]    bytecnt_q, bytecnt_d;
   logic [BYTE_W-1:0]   pend_q, pend_d;
   logic                pend_vld_q, pend_vld_d;
   logic                frame_prev_q;
   logic                err_partial_q, err_partial_d;
   logic                err_overflow_q, err_overflow_d;
   logic                err_long_q, err_long_d;
   logic                busy_q, busy_d;

   logic                push;
   fifo_entry_t         push_entry;
   fifo_entry_t         head;
   logic                fifo_full;
   logic                fifo_empty;
   logic                at_max;

   assign at_max = (bytecnt_q == CNT_W'(MAX_BYTES));

   // Next-state, byte assembly and push decisions.
   always_comb begin
      state_d         = state_q;
      shift_d         = shift_q;
      bitcnt_d        = bitcnt_q;
      bytecnt_d       = bytecnt_q;
      pend_d          = pend_q;
      pend_vld_d      = pend_vld_q;
      push            = 1'b0;
      push_entry.last = 1'b0;
      push_entry.data = pend_q;
      err_partial_d   = 1'b0;
      err_long_d      = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (frame) begin
               if (frame_prev_q) begin
                  // Frame was already high coming out of reset: wait for it to drop.
                  state_d = DISCARD;
               end else begin
                  state_d = SHIFT;
                  if (bit_valid) begin
                     shift_d  = {{(BYTE_W-2){1'b0}}, bit_data};
                     bitcnt_d = 3'd1;
                  end else begin
                     bitcnt_d = 3'd0;
                  end
               end
            end
         end

         SHIFT: begin
            if (!frame) begin
               push            = pend_vld_q;
               push_entry.last = 1'b1;
               err_partial_d   = (bitcnt_q != 3'd0);
               shift_d         = '0;
               bitcnt_d        = '0;
               bytecnt_d       = '0;
               pend_vld_d      = 1'b0;
               state_d         = IDLE;
            end else if (bit_valid) begin
               shift_d  = {shift_q[BYTE_W-3:0], bit_data};
               bitcnt_d = bitcnt_q + 3'd1;
               // At the byte limit the pending byte is held, since it can only be last.
               if (pend_vld_q && (bitcnt_q == 3'd0) && !at_max) begin
                  push       = 1'b1;
                  pend_vld_d = 1'b0;
               end
               if (bitcnt_q == 3'd7) begin
                  if (at_max) begin
                     push            = pend_vld_q;
                     push_entry.last = 1'b1;
                     err_long_d      = 1'b1;
                     shift_d         = '0;
                     bitcnt_d        = '0;
                     bytecnt_d       = '0;
                     pend_vld_d      = 1'b0;
                     state_d         = DISCARD;
                  end else begin
                     pend_d     = {shift_q, bit_data};
                     pend_vld_d = 1'b1;
                     bytecnt_d  = bytecnt_q + CNT_W'(1);
                  end
               end
            end
         end

         DISCARD: begin
            if (!frame) state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase

      // When full, m_valid is high, so a pop happens exactly when m_ready is high.
      err_overflow_d = push && fifo_full && !m_ready;
      busy_d         = (state_d != IDLE) || pend_vld_d;
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         shift_q        <= '0;
         bitcnt_q       <= '0;
         bytecnt_q      <= '0;
         pend_q         <= '0;
         pend_vld_q     <= 1'b0;
         frame_prev_q   <= 1'b1;
         err_partial_q  <= 1'b0;
         err_overflow_q <= 1'b0;
         err_long_q     <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         shift_q        <= shift_d;
         bitcnt_q       <= bitcnt_d;
         bytecnt_q      <= bytecnt_d;
         pend_q         <= pend_d;
         pend_vld_q     <= pend_vld_d;
         frame_prev_q   <= frame;
         err_partial_q  <= err_partial_d;
         err_overflow_q <= err_overflow_d;
         err_long_q     <= err_long_d;
         busy_q         <= busy_d;
      end
   end

   s2p_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_entry (push_entry),
      .pop        (m_ready),
      .head       (head),
      .full       (fifo_full),
      .empty      (fifo_empty)
   );

   assign m_valid      = !fifo_empty;
   assign m_data       = head.data;
   assign m_last       = head.last;
   assign err_partial  = err_partial_q;
   assign err_overflow = err_overflow_q;
   assign err_long     = err_long_q;
   assign busy         = busy_q;

endmodule
